// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Used by seg_scan_ctrl, which has an optional SEG_SCAN_DP_EN build.
package seg_pkg;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  typedef logic [3:0] nibble_t;

  localparam logic ANODE_OFF = 1'b1;

endpackage

// File: rtl/seg_scan_prescaler.sv
// Slot prescaler for seg_scan_ctrl: cnt runs 0..CLK_DIV-1 and wraps.
// It flags the last cycle of a slot and the last cycle of the blanking window.
module seg_scan_prescaler #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  output logic slot_tick,
  output logic blank_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign slot_tick  = (cnt_q == CNT_LAST);
  assign blank_done = (cnt_q == BLANK_LAST);

  always_comb begin
    cnt_d = slot_tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Define SEG_SCAN_DP_EN to add the wr_dp input and dp_n decimal-point output.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  output logic                    wr_ready,
  input  logic                    lz_supp,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start
`ifdef SEG_SCAN_DP_EN
  ,
  input  logic [NUM_DIGITS-1:0]   wr_dp,
  output logic                    dp_n
`endif
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic slot_tick, blank_done;

  seg_scan_prescaler #(
    .CLK_DIV  (CLK_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .slot_tick (slot_tick),
    .blank_done(blank_done)
  );

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] staged_q, staged_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  nibble_t                 bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_start_q, frame_start_d;
  logic                    upper_zero, suppressed, lit;

  assign wr_ready    = !pending_q;
  assign bcd_out     = bcd_q;
  assign an_n        = an_q;
  assign frame_start = frame_start_q;

  // Registered outputs are computed from next-state values so they line up
  // with the state they describe.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    staged_d  = staged_q;
    active_d  = active_q;

    case (state_q)
      BLANK:   if (blank_done) state_d = DRIVE;
      DRIVE:   if (slot_tick)  state_d = BLANK;
      default: state_d = BLANK;
    endcase

    if (slot_tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    // pending is high at commit time, so commit and accept are exclusive.
    if (slot_tick && idx_q == IDX_LAST && pending_q) begin
      active_d  = staged_q;
      pending_d = 1'b0;
    end else if (wr_valid && !pending_q) begin
      staged_d  = wr_data;
      pending_d = 1'b1;
    end

    upper_zero = 1'b1;
    bcd_d      = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(idx_d) && active_d[4*k +: 4] != 4'h0) upper_zero = 1'b0;
      if (idx_d == IW'(k)) bcd_d = active_d[4*k +: 4];
    end
    suppressed = lz_supp && (idx_d != '0) && upper_zero;
    lit        = (state_d == DRIVE) && !suppressed;

    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_d[k] = (lit && idx_d == IW'(k)) ? !ANODE_OFF : ANODE_OFF;
    end

    frame_start_d = slot_tick && (idx_d == '0);
  end

`ifdef SEG_SCAN_DP_EN
  logic [NUM_DIGITS-1:0] staged_dp_q, staged_dp_d;
  logic [NUM_DIGITS-1:0] active_dp_q, active_dp_d;
  logic                  dp_q, dp_d;

  assign dp_n = dp_q;

  always_comb begin
    staged_dp_d = staged_dp_q;
    active_dp_d = active_dp_q;
    if (slot_tick && idx_q == IDX_LAST && pending_q) active_dp_d = staged_dp_q;
    else if (wr_valid && !pending_q)                 staged_dp_d = wr_dp;
    dp_d = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (lit && idx_d == IW'(k)) dp_d = !active_dp_d[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      staged_dp_q <= '0;
      active_dp_q <= '0;
      dp_q        <= 1'b1;
    end else begin
      staged_dp_q <= staged_dp_d;
      active_dp_q <= active_dp_d;
      dp_q        <= dp_d;
    end
  end
`endif

  // The cycle after a reset edge is the first cycle of slot 0, so the
  // frame pulse is loaded high there.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BLANK;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      staged_q      <= '0;
      active_q      <= '0;
      bcd_q         <= '0;
      an_q          <= {NUM_DIGITS{ANODE_OFF}};
      frame_start_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      staged_q      <= staged_d;
      active_q      <= active_d;
      bcd_q         <= bcd_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomised bench for seg_scan_ctrl against a cycle-index reference model.
// Build with SEG_SCAN_DP_EN defined to also cover the decimal-point output.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int CD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        lz_supp;
  logic [3:0]  bcd_out;
  logic [3:0]  an_n;
  logic        frame_start;
`ifdef SEG_SCAN_DP_EN
  logic [3:0]  wr_dp;
  logic        dp_n;
  logic [3:0]  m_sdp, m_adp;
`endif

  int          checks = 0;
  int          errors = 0;

  // Reference model: position in the scan follows directly from the cycle
  // count since reset; words move staged -> active at the last cycle of a frame.
  int          m_t;
  logic        m_pending;
  logic [15:0] m_staged, m_active;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS(ND),
    .CLK_DIV   (CD),
    .BLANK_CYC (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .lz_supp    (lz_supp),
    .bcd_out    (bcd_out),
    .an_n       (an_n),
    .frame_start(frame_start)
`ifdef SEG_SCAN_DP_EN
    ,
    .wr_dp      (wr_dp),
    .dp_n       (dp_n)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0h expected %0h", tag, m_t, got, exp);
    end
  endtask

  task automatic step();
    int         pos, dig;
    logic       lit;
    logic [3:0] exp_an;
    @(posedge clk);
    if (rst) begin
      m_t       = 0;
      m_pending = 1'b0;
      m_staged  = '0;
      m_active  = '0;
`ifdef SEG_SCAN_DP_EN
      m_sdp     = '0;
      m_adp     = '0;
`endif
    end else begin
      pos = m_t % CD;
      dig = (m_t / CD) % ND;
      if (pos == CD-1 && dig == ND-1 && m_pending) begin
        m_active  = m_staged;
`ifdef SEG_SCAN_DP_EN
        m_adp     = m_sdp;
`endif
        m_pending = 1'b0;
      end else if (wr_valid && !m_pending) begin
        m_staged  = wr_data;
`ifdef SEG_SCAN_DP_EN
        m_sdp     = wr_dp;
`endif
        m_pending = 1'b1;
      end
      m_t++;
    end
    pos    = m_t % CD;
    dig    = (m_t / CD) % ND;
    lit    = (pos >= BC) && !(lz_supp && dig > 0 && (m_active >> (4*dig)) == 16'h0);
    exp_an = lit ? ~(4'b0001 << dig) : 4'hF;
    #1;
    check("frame_start", frame_start, (pos == 0 && dig == 0));
    check("an_n", an_n, exp_an);
    check("wr_ready", wr_ready, !m_pending);
    if (lit) check("bcd_out", bcd_out, (m_active >> (4*dig)) & 16'hF);
`ifdef SEG_SCAN_DP_EN
    check("dp_n", dp_n, lit ? !m_adp[dig] : 1'b1);
`endif
  endtask

  initial begin
    rst       = 1'b1;
    wr_valid  = 1'b0;
    wr_data   = '0;
    lz_supp   = 1'b0;
`ifdef SEG_SCAN_DP_EN
    wr_dp     = '0;
    m_sdp     = '0;
    m_adp     = '0;
`endif
    m_t       = 0;
    m_pending = 1'b0;
    m_staged  = '0;
    m_active  = '0;

    repeat (3) step();
    rst = 1'b0;
    repeat (40) step();

    repeat (5) step();
    wr_valid = 1'b1;
    wr_data  = 16'h1A3F;
`ifdef SEG_SCAN_DP_EN
    wr_dp    = 4'b0100;
`endif
    step();
    wr_valid = 1'b0;
    repeat (70) step();

    wr_valid = 1'b1;
    wr_data  = 16'h1111;
    step();
    wr_data  = 16'h2222;
    repeat (80) step();
    wr_valid = 1'b0;
    repeat (40) step();

    lz_supp  = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 16'h0030;
    step();
    wr_valid = 1'b0;
    repeat (70) step();
    wr_valid = 1'b1;
    wr_data  = 16'h0000;
    step();
    wr_valid = 1'b0;
    repeat (70) step();

    repeat (3) step();
    wr_valid = 1'b1;
    wr_data  = 16'h9999;
    step();
    wr_valid = 1'b0;
    repeat (12) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (40) step();

    for (int i = 0; i < 3000; i++) begin
      wr_valid = ($urandom_range(0, 7) == 0);
      wr_data  = 16'($urandom & (32'hFFFF >> (4 * $urandom_range(0, 4))));
`ifdef SEG_SCAN_DP_EN
      wr_dp    = 4'($urandom);
`endif
      if ($urandom_range(0, 49) == 0) lz_supp = ~lz_supp;
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
